// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives a combinational-read instruction
// memory and queues {pc, instr} pairs in a small prefetch FIFO for decode.
module instr_fetch_ctrl #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned              FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready,
    output logic                  idle
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  instr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [ADDR_WIDTH-1:0]  last_pc;
    logic [DATA_WIDTH-1:0]  last_instr;

    logic                   pop;
    logic                   pop_eff;
    logic                   push;
    logic                   full;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic                   unused_redirect_low;

    assign unused_redirect_low = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    assign mem_addr  = fetch_pc;
    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    // A pop coinciding with a redirect is void; the flush discards the head anyway.
    assign pop_eff   = pop && !redirect_valid;
    assign push      = (state == RUN) && !halt_req && !redirect_valid && (!full || pop);
    assign idle      = (state == HALTED);

    // While empty, present the last head so decode sees stable (don't-care) values.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : last_pc;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : last_instr;

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (halt_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!halt_req) begin
                    state_next = RUN;
                end else if ((count == '0) || ((count == CNT_W'(1)) && pop)) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (redirect_valid) begin
            state_next = (state == DRAIN) ? HALTED : state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= mem_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc    <= '0;
            last_instr <= '0;
        end else if (out_valid) begin
            last_pc    <= pc_mem[rd_ptr];
            last_instr <= instr_mem[rd_ptr];
        end
    end

endmodule
